// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 signed divider.
package div_pkg;

    localparam int unsigned OPW  = 40;
    localparam int unsigned RESW = 2 * OPW;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_e;

    localparam logic [OPW-1:0] DIV0_QUOT = '1;

    function automatic logic [OPW-1:0] neg(input logic [OPW-1:0] x);
        return (~x) + {{(OPW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract |b|.
module div_step #(
    parameter int unsigned W = 40
) (
    input  logic [W-1:0] r,
    input  logic         a_msb,
    input  logic [W-1:0] b_mag,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    logic [W:0] r_shift;
    logic [W:0] diff;

    // One extra bit so the borrow of the trial subtraction is the compare result.
    assign r_shift = {r, a_msb};
    assign diff    = r_shift - {1'b0, b_mag};
    assign q_bit   = ~diff[W];
    assign r_next  = q_bit ? diff[W-1:0] : r_shift[W-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 signed divider with independent operand slots and a registered result.
module div_iter #(
    parameter int unsigned OPW  = div_pkg::OPW,
    parameter int unsigned RESW = div_pkg::RESW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_dividend_tvalid,
    output logic            s_dividend_tready,
    input  logic [OPW-1:0]  s_dividend_tdata,
    input  logic            s_divisor_tvalid,
    output logic            s_divisor_tready,
    input  logic [OPW-1:0]  s_divisor_tdata,
    output logic            m_res_tvalid,
    input  logic            m_res_tready,
    output logic [RESW-1:0] m_res_tdata
);
    import div_pkg::*;

    localparam int unsigned CW = $clog2(OPW);

    div_state_e      state_q, state_d;
    logic [OPW-1:0]  dividend_q, divisor_q;
    logic            dividend_full_q, divisor_full_q;
    logic [OPW-1:0]  a_q, b_mag_q, r_q, q_q;
    logic            sign_a_q, sign_b_q;
    logic [CW-1:0]   cnt_q;
    logic [RESW-1:0] res_q;

    logic [OPW-1:0]  r_next, a_abs, b_abs, quot_fix, rem_fix;
    logic            q_bit;
    logic            dividend_fire, divisor_fire, res_fire;

    assign s_dividend_tready = !rst && !dividend_full_q && (state_q == StIdle);
    assign s_divisor_tready  = !rst && !divisor_full_q && (state_q == StIdle);
    assign m_res_tvalid      = !rst && (state_q == StDone);
    assign m_res_tdata       = res_q;

    assign dividend_fire = s_dividend_tvalid && s_dividend_tready;
    assign divisor_fire  = s_divisor_tvalid && s_divisor_tready;
    assign res_fire      = m_res_tvalid && m_res_tready;

    assign a_abs = dividend_q[OPW-1] ? neg(dividend_q) : dividend_q;
    assign b_abs = divisor_q[OPW-1] ? neg(divisor_q) : divisor_q;

    div_step #(
        .W(OPW)
    ) u_step (
        .r     (r_q),
        .a_msb (a_q[OPW-1]),
        .b_mag (b_mag_q),
        .r_next(r_next),
        .q_bit (q_bit)
    );

    always_comb begin
        quot_fix = (sign_a_q ^ sign_b_q) ? neg(q_q) : q_q;
        rem_fix  = sign_a_q ? neg(r_q) : r_q;
        // Operand registers still hold the original values, so divide-by-zero reads them here.
        if (divisor_q == '0) begin
            quot_fix = DIV0_QUOT;
            rem_fix  = dividend_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (dividend_full_q && divisor_full_q) state_d = StCalc;
            StCalc: if (cnt_q == '0) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: if (m_res_tready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            dividend_full_q <= 1'b0;
            divisor_full_q  <= 1'b0;
            res_q           <= '0;
        end else begin
            state_q <= state_d;
            if (dividend_fire) dividend_full_q <= 1'b1;
            if (divisor_fire) divisor_full_q <= 1'b1;
            if (res_fire) begin
                dividend_full_q <= 1'b0;
                divisor_full_q  <= 1'b0;
            end
            if (state_q == StFix) res_q <= {quot_fix, rem_fix};
        end
    end

    always_ff @(posedge clk) begin
        if (dividend_fire) dividend_q <= s_dividend_tdata;
        if (divisor_fire) divisor_q <= s_divisor_tdata;
        unique case (state_q)
            StIdle: begin
                if (dividend_full_q && divisor_full_q) begin
                    sign_a_q <= dividend_q[OPW-1];
                    sign_b_q <= divisor_q[OPW-1];
                    a_q      <= a_abs;
                    b_mag_q  <= b_abs;
                    r_q      <= '0;
                    q_q      <= '0;
                    cnt_q    <= CW'(OPW - 1);
                end
            end
            StCalc: begin
                r_q <= r_next;
                q_q <= {q_q[OPW-2:0], q_bit};
                a_q <= {a_q[OPW-2:0], 1'b0};
                if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: latency, signs, div-by-zero, backpressure, reset.
module tb_div_iter;

    logic        clk, rst;
    logic        s_dividend_tvalid, s_dividend_tready;
    logic [39:0] s_dividend_tdata;
    logic        s_divisor_tvalid, s_divisor_tready;
    logic [39:0] s_divisor_tdata;
    logic        m_res_tvalid, m_res_tready;
    logic [79:0] m_res_tdata;

    int total = 0;
    int bad   = 0;

    div_iter dut (
        .clk              (clk),
        .rst              (rst),
        .s_dividend_tvalid(s_dividend_tvalid),
        .s_dividend_tready(s_dividend_tready),
        .s_dividend_tdata (s_dividend_tdata),
        .s_divisor_tvalid (s_divisor_tvalid),
        .s_divisor_tready (s_divisor_tready),
        .s_divisor_tdata  (s_divisor_tdata),
        .m_res_tvalid     (m_res_tvalid),
        .m_res_tready     (m_res_tready),
        .m_res_tdata      (m_res_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive both operands in the current cycle; returns one cycle after the handshake edge (T+1).
    task automatic send_both(input logic [39:0] a, input logic [39:0] b);
        s_dividend_tdata  = a;
        s_divisor_tdata   = b;
        s_dividend_tvalid = 1'b1;
        s_divisor_tvalid  = 1'b1;
        step();
        s_dividend_tvalid = 1'b0;
        s_divisor_tvalid  = 1'b0;
    endtask

    // Called at T+1; lat is the k of the first cycle T+k with tvalid high (bounded).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!m_res_tvalid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        total++;
        if (s_dividend_tready !== 1'b0 || s_divisor_tready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b%b want 00", s_dividend_tready, s_divisor_tready);
        end
        total++;
        if (m_res_tvalid !== 1'b0 || m_res_tdata !== 80'd0) begin
            bad++;
            $display("FAIL reset_out: got v=%b d=%h want v=0 d=0", m_res_tvalid, m_res_tdata);
        end
        rst = 1'b0;
        step();
        total++;
        if (s_dividend_tready !== 1'b1 || s_divisor_tready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready: got %b%b want 11", s_dividend_tready, s_divisor_tready);
        end
    endtask

    task automatic test_basic();
        int lat;
        send_both(40'd100, 40'd7);
        wait_valid(lat);
        total++;
        if (lat !== 43) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 43", lat);
        end
        total++;
        if (m_res_tdata !== {40'd14, 40'd2}) begin
            bad++;
            $display("FAIL basic_data: got %h want %h", m_res_tdata, {40'd14, 40'd2});
        end
        step();
        total++;
        if (m_res_tvalid !== 1'b0 || s_dividend_tready !== 1'b1 || s_divisor_tready !== 1'b1) begin
            bad++;
            $display("FAIL basic_release: got v=%b rdy=%b%b want v=0 rdy=11", m_res_tvalid,
                     s_dividend_tready, s_divisor_tready);
        end
    endtask

    task automatic test_signed();
        int lat;
        // -7 / 2 truncates toward zero: q = -3, r = -1
        send_both(40'hFFFFFFFFF9, 40'd2);
        wait_valid(lat);
        total++;
        if (lat !== 43 || m_res_tdata !== {40'hFFFFFFFFFD, 40'hFFFFFFFFFF}) begin
            bad++;
            $display("FAIL signed_m7_2: got lat=%0d d=%h want lat=43 d=%h", lat, m_res_tdata,
                     {40'hFFFFFFFFFD, 40'hFFFFFFFFFF});
        end
        step();
        send_both(40'hFF80000000, 40'hFFFFFFFFFF);
        wait_valid(lat);
        total++;
        if (lat !== 43 || m_res_tdata !== {40'h0080000000, 40'd0}) begin
            bad++;
            $display("FAIL signed_min_m1: got lat=%0d d=%h want lat=43 d=%h", lat, m_res_tdata,
                     {40'h0080000000, 40'd0});
        end
        step();
    endtask

    task automatic test_unsigned_div0();
        int lat;
        send_both(40'h00FFFFFFFF, 40'd16);
        wait_valid(lat);
        total++;
        if (lat !== 43 || m_res_tdata !== {40'h000FFFFFFF, 40'd15}) begin
            bad++;
            $display("FAIL unsigned_max: got lat=%0d d=%h want lat=43 d=%h", lat, m_res_tdata,
                     {40'h000FFFFFFF, 40'd15});
        end
        step();
        send_both(40'd5, 40'd0);
        wait_valid(lat);
        total++;
        if (lat !== 43 || m_res_tdata !== {40'hFFFFFFFFFF, 40'd5}) begin
            bad++;
            $display("FAIL div0: got lat=%0d d=%h want lat=43 d=%h", lat, m_res_tdata,
                     {40'hFFFFFFFFFF, 40'd5});
        end
        step();
    endtask

    task automatic test_staggered();
        int lat;
        logic rdy_leak;
        s_divisor_tdata  = 40'd7;
        s_divisor_tvalid = 1'b1;
        step();
        s_divisor_tvalid = 1'b0;
        rdy_leak = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (s_divisor_tready !== 1'b0 || s_dividend_tready !== 1'b1) rdy_leak = 1'b1;
            step();
        end
        total++;
        if (s_divisor_tready !== 1'b0 || s_dividend_tready !== 1'b1 || rdy_leak) begin
            bad++;
            $display("FAIL stagger_wait_ready: got dvs=%b dvd=%b leak=%b want dvs=0 dvd=1 leak=0",
                     s_divisor_tready, s_dividend_tready, rdy_leak);
        end
        // -100 / 7: q = -14, r = -2
        s_dividend_tdata  = 40'hFFFFFFFF9C;
        s_dividend_tvalid = 1'b1;
        step();
        s_dividend_tvalid = 1'b0;
        lat = 1;
        while (!m_res_tvalid && lat < 100) begin
            if (s_divisor_tready !== 1'b0 || s_dividend_tready !== 1'b0) rdy_leak = 1'b1;
            step();
            lat++;
        end
        total++;
        if (lat !== 43 || rdy_leak) begin
            bad++;
            $display("FAIL stagger_latency: got lat=%0d leak=%b want lat=43 leak=0", lat, rdy_leak);
        end
        total++;
        if (m_res_tdata !== {40'hFFFFFFFFF2, 40'hFFFFFFFFFE}) begin
            bad++;
            $display("FAIL stagger_data: got %h want %h", m_res_tdata,
                     {40'hFFFFFFFFF2, 40'hFFFFFFFFFE});
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [79:0] held;
        logic unstable;
        m_res_tready = 1'b0;
        send_both(40'd100, 40'd7);
        wait_valid(lat);
        held = m_res_tdata;
        unstable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m_res_tvalid !== 1'b1 || m_res_tdata !== held || s_dividend_tready !== 1'b0 ||
                s_divisor_tready !== 1'b0) unstable = 1'b1;
        end
        total++;
        if (lat !== 43 || unstable || held !== {40'd14, 40'd2}) begin
            bad++;
            $display("FAIL backpressure_hold: got lat=%0d unstable=%b d=%h want lat=43 0 %h", lat,
                     unstable, held, {40'd14, 40'd2});
        end
        m_res_tready = 1'b1;
        step();
        total++;
        if (m_res_tvalid !== 1'b0 || s_dividend_tready !== 1'b1 || s_divisor_tready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release: got v=%b rdy=%b%b want v=0 rdy=11", m_res_tvalid,
                     s_dividend_tready, s_divisor_tready);
        end
        // 1000 / -3: q = -333, r = +1
        send_both(40'd1000, 40'hFFFFFFFFFD);
        wait_valid(lat);
        total++;
        if (lat !== 43 || m_res_tdata !== {40'hFFFFFFFEB3, 40'd1}) begin
            bad++;
            $display("FAIL back_to_back: got lat=%0d d=%h want lat=43 d=%h", lat, m_res_tdata,
                     {40'hFFFFFFFEB3, 40'd1});
        end
        step();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        send_both(40'd999, 40'd3);
        // now at T+1; CALC iteration 20 is cycle T+21
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        #1;
        total++;
        if (s_dividend_tready !== 1'b0 || s_divisor_tready !== 1'b0 || m_res_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_held: got rdy=%b%b v=%b want rdy=00 v=0", s_dividend_tready,
                     s_divisor_tready, m_res_tvalid);
        end
        step();
        rst = 1'b0;
        #1;
        total++;
        if (s_dividend_tready !== 1'b1 || s_divisor_tready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_ready: got %b%b want 11", s_dividend_tready, s_divisor_tready);
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (m_res_tvalid !== 1'b0) seen = 1'b1;
            step();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_no_valid: got tvalid seen=%b want 0", seen);
        end
        send_both(40'd100, 40'd7);
        wait_valid(lat);
        total++;
        if (lat !== 43 || m_res_tdata !== {40'd14, 40'd2}) begin
            bad++;
            $display("FAIL mid_reset_rerun: got lat=%0d d=%h want lat=43 d=%h", lat, m_res_tdata,
                     {40'd14, 40'd2});
        end
        step();
    endtask

    initial begin
        rst               = 1'b1;
        s_dividend_tvalid = 1'b0;
        s_divisor_tvalid  = 1'b0;
        s_dividend_tdata  = '0;
        s_divisor_tdata   = '0;
        m_res_tready      = 1'b1;
        step();
        step();
        test_reset();
        test_basic();
        test_signed();
        test_unsigned_div0();
        test_staggered();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
